utm_rrq_arb: RTL and testbench
==============================

# utm_rrq_arb

Read-request arbiter and tag manager for the Unicast Tag Manager (UTM) in the EGR partition. It shares the single UTM-to-MRI read-request port among NUM_REQ internal requesters (DPB, PFS and PRC paths), using round-robin arbitration. It allocates a unique tag to each issued read and tracks outstanding tags. It routes each MRI read response back to the requester that issued it.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (index 0 = DPB, 1 = PFS, 2 = PRC).
- ADDR_W, 20, read address width.
- DATA_W, 64, response data width.
- NUM_TAGS, 16, maximum outstanding reads; TAG_W = $clog2(NUM_TAGS).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  per-requester accept.
- rrq_valid  out  1  request to MRI valid.
- rrq_ready  in  1  MRI accepts request.
- rrq_addr  out  ADDR_W  request address.
- rrq_tag  out  TAG_W  allocated tag.
- rrs_valid  in  1  MRI response valid (no backpressure).
- rrs_tag  in  TAG_W  response tag.
- rrs_data  in  DATA_W  response data.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_data  out  DATA_W  response data, broadcast to all requesters.
- outstanding  out  TAG_W+1  count of allocated tags.
- err_bad_tag  out  1  sticky flag: a response arrived for an unallocated tag.

## Operation
- Reset state: rrq_valid=0, rrq_addr=0, rrq_tag=0, rsp_valid=0, rsp_data=0, outstanding=0, err_bad_tag=0. All tags are free. The round-robin pointer is 0.
- Output stage: a single register holds rrq_valid, rrq_addr and rrq_tag. The stage can load when `!rrq_valid || rrq_ready`.
- Arbitration runs when the output stage can load and at least one tag is free.
  - Round-robin search starts at the pointer; the first requester with req_valid set wins.
  - req_ready is asserted for the winner only, in the same cycle. It depends combinationally on req_valid, rrq_ready and the free-tag state.
- Accept = req_valid[i] && req_ready[i]. On accept:
  - The lowest-indexed free tag is allocated.
  - The tag-owner table entry for that tag is written with i.
  - The output register loads the address and tag, with rrq_valid=1.
  - The pointer moves to (i+1) mod NUM_REQ.
  - With no accept, the pointer holds.
- While rrq_valid && !rrq_ready, rrq_addr and rrq_tag hold stable and no requester is granted.
- Response path on rrs_valid:
  - If the tag is allocated: the tag is freed, rsp_data is registered, and rsp_valid[owner] is driven for exactly one cycle.
  - If the tag is unallocated: the response is dropped, err_bad_tag is set, and the free state is unchanged.
  - err_bad_tag is cleared only by reset.
- outstanding = number of allocated tags. It increments on accept and decrements on a valid free. Both in one cycle leave it unchanged.

## Timing
- Request accept to rrq_valid high: 1 cycle.
  - With rrq_ready held high, one request is issued per cycle.
- rrs_valid to rsp_valid: 1 cycle.
  - rsp_valid can be asserted on back-to-back cycles.
- Full (outstanding == NUM_TAGS): all req_ready are 0.
  - A tag freed in cycle N can be allocated in cycle N+1, not in cycle N.
- A tag that is allocated and freed in the same cycle cannot occur, because allocation only selects tags that are free at the start of the cycle.
- Asserting arst_n low mid-operation has these effects:
  - All in-flight tags are abandoned.
  - Outputs return to their reset values immediately (asynchronously).
  - Responses that arrive after reset for the old tags set err_bad_tag.

## Test plan
- Single request: req_valid[1]=1, addr 0x00ABC, rrq_ready=1.
  - Expected: req_ready[1] in the same cycle; next cycle rrq_valid=1, rrq_addr=0x00ABC, rrq_tag=0, outstanding=1.
  - Then rrs_valid with tag 0 and data 0xDEAD → next cycle rsp_valid=3'b010, rsp_data=0xDEAD, outstanding=0.
- Fairness: all three requesters hold req_valid for 6 cycles with rrq_ready=1.
  - Expected grant order 0,1,2,0,1,2 and tags 0..5.
- Backpressure: rrq_ready=0 for 4 cycles after the first issue.
  - Expected: rrq_addr/rrq_tag stable, req_ready=0, no tag allocated.
  - On release, the next grant goes to the next requester in round-robin order.
- Exhaustion: 16 accepts with no responses.
  - Expected: outstanding=16 and req_ready all 0.
  - Then a response for tag 7 → in the following cycle the pending requester is accepted with rrq_tag=7 and outstanding stays 16.
- Bad tag: rrs_valid with tag 3 while tag 3 is free.
  - Expected: rsp_valid stays 0, err_bad_tag=1 and held, outstanding unchanged.
- Reset mid-flight: assert arst_n low with 5 outstanding and rrq_valid=1.
  - Expected: immediate rrq_valid=0 and outstanding=0.
  - After release, the first issue uses tag 0 from requester 0.

Source files
------------

// File: rtl/utm_rrq_arb_if.sv
// Bundle of the requester-side, MRI request and MRI response signals of the UTM read-request arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus MRI.
interface utm_rrq_arb_if #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 64,
    parameter int NUM_TAGS = 16
);
    localparam int TAG_W = $clog2(NUM_TAGS);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rrq_valid;
    logic                      rrq_ready;
    logic [ADDR_W-1:0]         rrq_addr;
    logic [TAG_W-1:0]          rrq_tag;
    logic                      rrs_valid;
    logic [TAG_W-1:0]          rrs_tag;
    logic [DATA_W-1:0]         rrs_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [TAG_W:0]            outstanding;
    logic                      err_bad_tag;

    modport master (
        input  req_valid, req_addr, rrq_ready, rrs_valid, rrs_tag, rrs_data,
        output req_ready, rrq_valid, rrq_addr, rrq_tag, rsp_valid, rsp_data,
               outstanding, err_bad_tag
    );

    modport slave (
        output req_valid, req_addr, rrq_ready, rrs_valid, rrs_tag, rrs_data,
        input  req_ready, rrq_valid, rrq_addr, rrq_tag, rsp_valid, rsp_data,
               outstanding, err_bad_tag
    );
endinterface

// File: rtl/utm_rrq_arb.sv
// Round-robin arbiter sharing the UTM-to-MRI read-request port, with tag allocation,
// outstanding-tag tracking and response routing back to the issuing requester.
module utm_rrq_arb #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 64,
    parameter int NUM_TAGS = 16
) (
    input  logic          clk,
    input  logic          arst_n,
    utm_rrq_arb_if.master bus
);
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int RID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_TAGS-1:0] free_q, free_d;
    logic [RID_W-1:0]    owner_q [NUM_TAGS];
    logic [RID_W-1:0]    ptr_q, ptr_d;
    logic                rrq_valid_q, rrq_valid_d;
    logic [ADDR_W-1:0]   rrq_addr_q, rrq_addr_d;
    logic [TAG_W-1:0]    rrq_tag_q, rrq_tag_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W:0]      outstanding_q, outstanding_d;
    logic                err_q, err_d;

    logic                can_load;
    logic                any_free;
    logic                found;
    logic [RID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic [TAG_W-1:0]    alloc_tag;
    logic                rsp_hit;
    logic                rsp_bad;

    // Grant logic: first requesting index at or after the pointer, gated by stage and tag availability.
    always_comb begin
        can_load  = !rrq_valid_q || bus.rrq_ready;
        any_free  = |free_q;
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                found     = 1'b1;
                grant_idx = RID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        if (found && can_load && any_free) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign accept = |grant;

    // Only tags free at the start of the cycle are candidates, so a tag freed now waits a cycle.
    always_comb begin
        alloc_tag = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (free_q[t]) begin
                alloc_tag = TAG_W'(t);
            end
        end
    end

    assign rsp_hit = bus.rrs_valid && !free_q[bus.rrs_tag];
    assign rsp_bad = bus.rrs_valid &&  free_q[bus.rrs_tag];

    always_comb begin
        free_d        = free_q;
        ptr_d         = ptr_q;
        rrq_valid_d   = rrq_valid_q;
        rrq_addr_d    = rrq_addr_q;
        rrq_tag_d     = rrq_tag_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        outstanding_d = outstanding_q;
        err_d         = err_q || rsp_bad;

        if (accept) begin
            free_d[alloc_tag] = 1'b0;
            rrq_valid_d       = 1'b1;
            rrq_addr_d        = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            rrq_tag_d         = alloc_tag;
            ptr_d             = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end else if (bus.rrq_ready) begin
            rrq_valid_d = 1'b0;
        end

        if (rsp_hit) begin
            free_d[bus.rrs_tag]             = 1'b1;
            rsp_valid_d[owner_q[bus.rrs_tag]] = 1'b1;
            rsp_data_d                      = bus.rrs_data;
        end

        case ({accept, rsp_hit})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            free_q        <= '1;
            ptr_q         <= '0;
            rrq_valid_q   <= 1'b0;
            rrq_addr_q    <= '0;
            rrq_tag_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            free_q        <= free_d;
            ptr_q         <= ptr_d;
            rrq_valid_q   <= rrq_valid_d;
            rrq_addr_q    <= rrq_addr_d;
            rrq_tag_q     <= rrq_tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Owner entries are only read for allocated tags, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[alloc_tag] <= grant_idx;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rrq_valid   = rrq_valid_q;
    assign bus.rrq_addr    = rrq_addr_q;
    assign bus.rrq_tag     = rrq_tag_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.outstanding = outstanding_q;
    assign bus.err_bad_tag = err_q;
endmodule

// File: tb/tb_utm_rrq_arb.sv
// Testbench for utm_rrq_arb: directed scenarios plus randomized traffic against a
// behavioural model that tracks allocated tags, owners and the round-robin pointer.
module tb_utm_rrq_arb;
    localparam int NR = 3;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int NT = 16;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    utm_rrq_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_TAGS(NT)) bus ();

    utm_rrq_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_TAGS(NT)) dut (
        .clk(clk), .arst_n(arst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_err = 0;

    // Reference model state
    bit          m_alloc [NT];
    int          m_owner [NT];
    int          m_ptr;
    bit          m_rv;
    logic [AW-1:0] m_addr;
    int          m_tag;
    logic [NR-1:0] m_rsp_valid;
    logic [DW-1:0] m_rsp_data;
    bit          m_err;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] obs_ready;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NT; i++) c += int'(m_alloc[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin m_alloc[i] = 0; m_owner[i] = 0; end
        m_ptr = 0; m_rv = 0; m_addr = '0; m_tag = 0;
        m_rsp_valid = '0; m_rsp_data = '0; m_err = 0;
    endtask

    task automatic model_comb();
        bit can_issue;
        exp_ready = '0;
        can_issue = (!m_rv || bus.rrq_ready) && (m_count() < NT);
        if (can_issue) begin
            for (int k = NR - 1; k >= 0; k--)
                if (bus.req_valid[(m_ptr + k) % NR]) exp_ready = NR'(1) << ((m_ptr + k) % NR);
        end
    endtask

    task automatic model_edge();
        int win = -1;
        int t = -1;
        bit hit, bad;
        for (int i = 0; i < NR; i++) if (exp_ready[i]) win = i;
        for (int k = NT - 1; k >= 0; k--) if (!m_alloc[k]) t = k;
        hit = bus.rrs_valid && m_alloc[bus.rrs_tag];
        bad = bus.rrs_valid && !m_alloc[bus.rrs_tag];
        m_rsp_valid = hit ? (NR'(1) << m_owner[bus.rrs_tag]) : '0;
        if (hit) begin m_rsp_data = bus.rrs_data; m_alloc[bus.rrs_tag] = 0; end
        if (bad) m_err = 1;
        if (win >= 0) begin
            m_alloc[t] = 1; m_owner[t] = win; m_rv = 1;
            m_addr = bus.req_addr[win*AW +: AW]; m_tag = t; m_ptr = (win + 1) % NR;
        end else if (bus.rrq_ready) begin
            m_rv = 0;
        end
    endtask

    // Entered and left at posedge+1; inputs must already be applied.
    task automatic step();
        #3;
        model_comb();
        obs_ready = bus.req_ready;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0; bus.req_addr = '0; bus.rrq_ready = 1'b1;
        bus.rrs_valid = 1'b0; bus.rrs_tag = '0; bus.rrs_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 arst_n = 1'b0;
        model_reset();
        @(posedge clk); #3 arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_n = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({bus.rrq_valid, bus.rrq_addr, bus.rrq_tag, bus.rsp_valid, bus.rsp_data,
             bus.outstanding, bus.err_bad_tag, bus.req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_state: rv=%0b addr=%h tag=%0d rsp=%b data=%h out=%0d err=%0b rdy=%b, required all zero",
                     bus.rrq_valid, bus.rrq_addr, bus.rrq_tag, bus.rsp_valid, bus.rsp_data,
                     bus.outstanding, bus.err_bad_tag, bus.req_ready);
        end
        @(posedge clk); #3 arst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 3'b010;
        bus.req_addr[1*AW +: AW] = 20'h00ABC;
        step();
        bus.req_valid = '0;
        n_checks++;
        if (obs_ready !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b required 010", obs_ready); end
        n_checks++;
        if ({bus.rrq_valid, bus.rrq_addr, bus.rrq_tag, bus.outstanding} !== {1'b1, 20'h00ABC, 4'd0, 5'd1}) begin
            n_err++;
            $display("FAIL single_issue: rv=%0b addr=%h tag=%0d out=%0d required 1 00abc 0 1",
                     bus.rrq_valid, bus.rrq_addr, bus.rrq_tag, bus.outstanding);
        end
        bus.rrs_valid = 1'b1; bus.rrs_tag = 4'd0; bus.rrs_data = 64'hDEAD;
        step();
        bus.rrs_valid = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.outstanding} !== {3'b010, 64'hDEAD, 5'd0}) begin
            n_err++;
            $display("FAIL single_rsp: rsp=%b data=%h out=%0d required 010 dead 0",
                     bus.rsp_valid, bus.rsp_data, bus.outstanding);
        end
        step();
        n_checks++;
        if (bus.rsp_valid !== 3'b000) begin n_err++; $display("FAIL single_rsp_pulse: rsp=%b required 000", bus.rsp_valid); end
        $display("test_single done");
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = 3'b111;
            for (int i = 0; i < NR; i++) bus.req_addr[i*AW +: AW] = AW'(32'h100 * (k + 1) + i);
            step();
            n_checks++;
            if (obs_ready !== (3'b001 << (k % 3)) || bus.rrq_tag !== 4'(k) ||
                bus.rrq_addr !== AW'(32'h100 * (k + 1) + (k % 3))) begin
                n_err++;
                $display("FAIL fairness_%0d: ready=%b tag=%0d addr=%h required ready=%b tag=%0d",
                         k, obs_ready, bus.rrq_tag, bus.rrq_addr, 3'b001 << (k % 3), k);
            end
        end
        bus.req_valid = '0;
        $display("test_fairness done");
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] held_addr;
        do_reset();
        bus.req_valid = 3'b111;
        bus.req_addr = {20'h33333, 20'h22222, 20'h11111};
        step();
        held_addr = bus.rrq_addr;
        bus.rrq_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (obs_ready !== 3'b000 || bus.rrq_valid !== 1'b1 || bus.rrq_tag !== 4'd0 ||
                bus.rrq_addr !== 20'h11111 || bus.outstanding !== 5'd1) begin
                n_err++;
                $display("FAIL backpressure_%0d: ready=%b rv=%0b tag=%0d addr=%h out=%0d required 000 1 0 11111 1",
                         k, obs_ready, bus.rrq_valid, bus.rrq_tag, bus.rrq_addr, bus.outstanding);
            end
        end
        bus.rrq_ready = 1'b1;
        step();
        bus.req_valid = '0;
        n_checks++;
        if (obs_ready !== 3'b010 || bus.rrq_tag !== 4'd1 || bus.rrq_addr !== 20'h22222) begin
            n_err++;
            $display("FAIL backpressure_release: ready=%b tag=%0d addr=%h required 010 1 22222",
                     obs_ready, bus.rrq_tag, bus.rrq_addr);
        end
        $display("test_backpressure done (first addr %h)", held_addr);
    endtask

    task automatic test_exhaust();
        do_reset();
        bus.req_valid = 3'b111;
        for (int k = 0; k < NT; k++) step();
        step();
        n_checks++;
        if (bus.outstanding !== 5'd16 || obs_ready !== 3'b000) begin
            n_err++;
            $display("FAIL exhaust_full: out=%0d ready=%b required 16 000", bus.outstanding, obs_ready);
        end
        bus.rrs_valid = 1'b1; bus.rrs_tag = 4'd7; bus.rrs_data = 64'h7777;
        step();
        bus.rrs_valid = 1'b0;
        n_checks++;
        if (obs_ready !== 3'b000 || bus.rsp_valid !== 3'b010 || bus.outstanding !== 5'd15) begin
            n_err++;
            $display("FAIL exhaust_free: ready=%b rsp=%b out=%0d required 000 010 15",
                     obs_ready, bus.rsp_valid, bus.outstanding);
        end
        step();
        bus.req_valid = '0;
        n_checks++;
        if (obs_ready !== 3'b010 || bus.rrq_tag !== 4'd7 || bus.outstanding !== 5'd16) begin
            n_err++;
            $display("FAIL exhaust_realloc: ready=%b tag=%0d out=%0d required 010 7 16",
                     obs_ready, bus.rrq_tag, bus.outstanding);
        end
        $display("test_exhaust done");
    endtask

    task automatic test_bad_tag();
        do_reset();
        bus.rrs_valid = 1'b1; bus.rrs_tag = 4'd3; bus.rrs_data = 64'hBAD;
        step();
        bus.rrs_valid = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 3'b000 || bus.err_bad_tag !== 1'b1 || bus.outstanding !== 5'd0) begin
            n_err++;
            $display("FAIL bad_tag: rsp=%b err=%0b out=%0d required 000 1 0",
                     bus.rsp_valid, bus.err_bad_tag, bus.outstanding);
        end
        repeat (3) step();
        n_checks++;
        if (bus.err_bad_tag !== 1'b1) begin n_err++; $display("FAIL bad_tag_sticky: err=%0b required 1", bus.err_bad_tag); end
        $display("test_bad_tag done");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.req_valid = 3'b111;
        repeat (5) step();
        bus.req_valid = '0;
        #1 arst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bus.rrq_valid !== 1'b0 || bus.outstanding !== 5'd0) begin
            n_err++;
            $display("FAIL midflight_async: rv=%0b out=%0d required 0 0", bus.rrq_valid, bus.outstanding);
        end
        @(posedge clk); #3 arst_n = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 3'b111;
        step();
        bus.req_valid = '0;
        n_checks++;
        if (obs_ready !== 3'b001 || bus.rrq_tag !== 4'd0 || bus.outstanding !== 5'd1) begin
            n_err++;
            $display("FAIL midflight_reissue: ready=%b tag=%0d out=%0d required 001 0 1",
                     obs_ready, bus.rrq_tag, bus.outstanding);
        end
        bus.rrs_valid = 1'b1; bus.rrs_tag = 4'd3; bus.rrs_data = 64'h3;
        step();
        bus.rrs_valid = 1'b0;
        n_checks++;
        if (bus.err_bad_tag !== 1'b1 || bus.rsp_valid !== 3'b000) begin
            n_err++;
            $display("FAIL midflight_stale_rsp: err=%0b rsp=%b required 1 000", bus.err_bad_tag, bus.rsp_valid);
        end
        $display("test_reset_midflight done");
    endtask

    task automatic test_random();
        int live [$];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = NR'($urandom);
            bus.req_addr  = (NR*AW)'({$urandom, $urandom});
            bus.rrq_ready = ($urandom_range(0, 99) < 70);
            live.delete();
            for (int i = 0; i < NT; i++) if (m_alloc[i]) live.push_back(i);
            bus.rrs_valid = 1'b0;
            bus.rrs_tag   = 4'($urandom);
            bus.rrs_data  = {$urandom, $urandom};
            if (live.size() > 0 && $urandom_range(0, 99) < 35) begin
                bus.rrs_valid = 1'b1;
                bus.rrs_tag   = 4'(live[$urandom_range(0, live.size() - 1)]);
            end else if (c > 550 && $urandom_range(0, 99) < 20) begin
                bus.rrs_valid = 1'b1;
            end
            step();
            n_checks++;
            if (obs_ready !== exp_ready || bus.rrq_valid !== m_rv || bus.rrq_addr !== m_addr ||
                bus.rrq_tag !== 4'(m_tag) || bus.rsp_valid !== m_rsp_valid ||
                bus.rsp_data !== m_rsp_data || bus.outstanding !== 5'(m_count()) ||
                bus.err_bad_tag !== m_err) begin
                n_err++;
                $display("FAIL random_%0d: ready=%b/%b rv=%0b/%0b addr=%h/%h tag=%0d/%0d rsp=%b/%b data=%h/%h out=%0d/%0d err=%0b/%0b (got/required)",
                         c, obs_ready, exp_ready, bus.rrq_valid, m_rv, bus.rrq_addr, m_addr,
                         bus.rrq_tag, m_tag, bus.rsp_valid, m_rsp_valid, bus.rsp_data, m_rsp_data,
                         bus.outstanding, m_count(), bus.err_bad_tag, m_err);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_exhaust();
        test_bad_tag();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
